// File: rtl/sw_ctrl_fsm.sv
// Stopwatch/countdown front-panel controller: button sync, debounce, mode/run/lap FSM.
// Optional LAP_CNT_EN adds a saturating lap counter output.
module sw_ctrl_fsm #(
    parameter int DEB_CYCLES   = 250000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int ALARM_CYCLES = 8
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       cd_zero,
    output logic       sw_run,
    output logic       sw_clr,
    output logic       lap,
    output logic       mode,
    output logic       cd_run,
    output logic       cd_load,
    output logic       alarm
`ifdef LAP_CNT_EN
    ,
    output logic [3:0] lap_cnt
`endif
);

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int HALF_W  = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [HALF_W-1:0]  HALF_MAX  = HALF_W'(ALARM_CYCLES - 1);

    typedef enum logic [3:0] {
        SW_IDLE,
        SW_RUN,
        SW_LAP,
        SW_LSTOP,
        SW_STOP,
        CD_IDLE,
        CD_RUN,
        CD_PAUSE,
        CD_DONE
    } state_t;

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_deb;
    logic [3:0]         r_deb_q;
    logic [DEB_W-1:0]   r_deb_cnt [4];

    state_t             r_state;
    state_t             w_next;
    logic               w_clr;
    logic               w_load;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic [HALF_W-1:0]  r_half_cnt;
    logic               w_half_end;
    logic               w_alarm_end;

    logic               r_sw_run;
    logic               r_sw_clr;
    logic               r_lap;
    logic               r_mode;
    logic               r_cd_run;
    logic               r_cd_load;
    logic               r_alarm;

    logic [3:0]         w_press;
    logic               w_ev_rst;
    logic               w_ev_mode;
    logic               w_ev_start;
    logic               w_ev_lap;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // The level only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_deb_q <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_MAX) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign w_press    = r_deb & ~r_deb_q;
    assign w_ev_rst   = w_press[2];
    assign w_ev_mode  = w_press[3] & ~w_press[2];
    assign w_ev_start = w_press[0] & ~w_press[2] & ~w_press[3];
    assign w_ev_lap   = w_press[1] & ~w_press[2] & ~w_press[3] & ~w_press[0];

    assign w_half_end  = (r_blink_cnt == BLINK_MAX);
    assign w_alarm_end = w_half_end & (r_half_cnt == HALF_MAX);

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_load = 1'b0;
        unique case (r_state)
            SW_IDLE: begin
                if (w_ev_start) begin
                    w_next = SW_RUN;
                end else if (w_ev_mode) begin
                    w_next = CD_IDLE;
                end
            end
            SW_RUN: begin
                if (w_ev_start) begin
                    w_next = SW_STOP;
                end else if (w_ev_lap) begin
                    w_next = SW_LAP;
                end
            end
            SW_LAP: begin
                if (w_ev_lap) begin
                    w_next = SW_RUN;
                end else if (w_ev_start) begin
                    w_next = SW_LSTOP;
                end
            end
            SW_LSTOP: begin
                if (w_ev_lap) begin
                    w_next = SW_STOP;
                end else if (w_ev_start) begin
                    w_next = SW_LAP;
                end else if (w_ev_rst) begin
                    w_next = SW_IDLE;
                    w_clr  = 1'b1;
                end
            end
            SW_STOP: begin
                if (w_ev_start) begin
                    w_next = SW_RUN;
                end else if (w_ev_rst) begin
                    w_next = SW_IDLE;
                    w_clr  = 1'b1;
                end else if (w_ev_mode) begin
                    w_next = CD_IDLE;
                end
            end
            CD_IDLE: begin
                if (w_ev_rst) begin
                    w_load = 1'b1;
                end else if (w_ev_start && !cd_zero) begin
                    w_next = CD_RUN;
                end else if (w_ev_mode) begin
                    w_next = SW_IDLE;
                end
            end
            CD_RUN: begin
                if (cd_zero) begin
                    w_next = CD_DONE;
                end else if (w_ev_start) begin
                    w_next = CD_PAUSE;
                end
            end
            CD_PAUSE: begin
                if (w_ev_start) begin
                    w_next = CD_RUN;
                end else if (w_ev_rst) begin
                    w_next = CD_IDLE;
                    w_load = 1'b1;
                end
            end
            CD_DONE: begin
                if (w_ev_start || w_ev_rst) begin
                    w_next = CD_IDLE;
                    w_load = 1'b1;
                end else if (w_ev_mode) begin
                    w_next = SW_IDLE;
                end else if (w_alarm_end) begin
                    w_next = CD_IDLE;
                    w_load = 1'b1;
                end
            end
            default: begin
                w_next = SW_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SW_IDLE;
            r_sw_run  <= 1'b0;
            r_sw_clr  <= 1'b0;
            r_lap     <= 1'b0;
            r_mode    <= 1'b0;
            r_cd_run  <= 1'b0;
            r_cd_load <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sw_run  <= (w_next == SW_RUN) || (w_next == SW_LAP);
            r_lap     <= (w_next == SW_LAP) || (w_next == SW_LSTOP);
            r_mode    <= (w_next == CD_IDLE) || (w_next == CD_RUN) ||
                         (w_next == CD_PAUSE) || (w_next == CD_DONE);
            r_cd_run  <= (w_next == CD_RUN);
            r_sw_clr  <= w_clr;
            r_cd_load <= w_load;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_half_cnt  <= '0;
            r_alarm     <= 1'b0;
        end else if (w_next != CD_DONE) begin
            r_blink_cnt <= '0;
            r_half_cnt  <= '0;
            r_alarm     <= 1'b0;
        end else if (r_state != CD_DONE) begin
            r_blink_cnt <= '0;
            r_half_cnt  <= '0;
            r_alarm     <= 1'b1;
        end else if (w_half_end) begin
            r_blink_cnt <= '0;
            r_alarm     <= ~r_alarm;
            if (r_half_cnt != HALF_MAX) begin
                r_half_cnt <= r_half_cnt + HALF_W'(1);
            end
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

`ifdef LAP_CNT_EN
    logic [3:0] r_lap_cnt;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_cnt <= '0;
        end else if (w_clr) begin
            r_lap_cnt <= '0;
        end else if (r_state == SW_RUN && w_next == SW_LAP &&
                     r_lap_cnt != 4'hF) begin
            r_lap_cnt <= r_lap_cnt + 4'd1;
        end
    end

    assign lap_cnt = r_lap_cnt;
`endif

    assign sw_run  = r_sw_run;
    assign sw_clr  = r_sw_clr;
    assign lap     = r_lap;
    assign mode    = r_mode;
    assign cd_run  = r_cd_run;
    assign cd_load = r_cd_load;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_sw_ctrl_fsm.sv
// Scoreboard bench for sw_ctrl_fsm: directed panel sequences then random presses,
// each cycle compared against a window/timer based reference model.
module tb_sw_ctrl_fsm;

    localparam int DEB    = 4;
    localparam int BLINK  = 2;
    localparam int ALARMN = 8;

    typedef enum int {
        M_IDLE, M_RUN, M_LAP, M_LSTOP, M_STOP,
        C_IDLE, C_RUN, C_PAUSE, C_DONE
    } mst_t;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       cd_zero = 1'b0;
    logic       sw_run, sw_clr, lap, mode, cd_run, cd_load, alarm;
    logic [3:0] dut_lcnt;
    logic [10:0] dut_v;

    int n_chk = 0;
    int n_pass = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    logic [3:0] m_s1, m_s2, m_deb, m_deb_prev;
    logic [3:0] m_hist[$];
    mst_t       m_st;
    int         m_t;
    int         m_lcnt;

    sw_ctrl_fsm #(
        .DEB_CYCLES  (DEB),
        .BLINK_CYCLES(BLINK),
        .ALARM_CYCLES(ALARMN)
    ) dut (
        .mclk   (mclk),
        .rst_n  (rst_n),
        .btn    (btn),
        .cd_zero(cd_zero),
        .sw_run (sw_run),
        .sw_clr (sw_clr),
        .lap    (lap),
        .mode   (mode),
        .cd_run (cd_run),
        .cd_load(cd_load),
        .alarm  (alarm)
`ifdef LAP_CNT_EN
        ,
        .lap_cnt(dut_lcnt)
`endif
    );

`ifndef LAP_CNT_EN
    assign dut_lcnt = 4'd0;
`endif

    assign dut_v = {dut_lcnt, sw_run, sw_clr, lap, mode, cd_run, cd_load, alarm};

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got {lcnt,run,clr,lap,mode,cdrun,load,alarm}=%b expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        m_deb = 4'd0;
        m_deb_prev = 4'd0;
        m_hist.delete();
        m_st = M_IDLE;
        m_t = 0;
        m_lcnt = 0;
    endtask

    // Sets the inputs for the coming edge and queues the outputs expected after it.
    task automatic apply(input logic [3:0] b, input logic cz, input string tag);
        logic [3:0]  press, nd;
        logic [10:0] e;
        mst_t        prev;
        int          ev;
        bit          clr, load, ok;
        press = m_deb & ~m_deb_prev;
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        nd = m_deb;
        for (int i = 0; i < 4; i++) begin
            if (m_hist.size() == DEB) begin
                ok = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) ok = 1'b0;
                if (ok) nd[i] = ~m_deb[i];
            end
        end
        m_deb_prev = m_deb;
        m_deb = nd;
        m_s2 = m_s1;
        m_s1 = b;
        ev = press[2] ? 1 : press[3] ? 2 : press[0] ? 3 : press[1] ? 4 : 0;
        clr = 1'b0;
        load = 1'b0;
        prev = m_st;
        case (m_st)
            M_IDLE:  if (ev == 3) m_st = M_RUN; else if (ev == 2) m_st = C_IDLE;
            M_RUN:   if (ev == 3) m_st = M_STOP; else if (ev == 4) m_st = M_LAP;
            M_LAP:   if (ev == 4) m_st = M_RUN; else if (ev == 3) m_st = M_LSTOP;
            M_LSTOP: begin
                if (ev == 4) m_st = M_STOP;
                else if (ev == 3) m_st = M_LAP;
                else if (ev == 1) begin m_st = M_IDLE; clr = 1'b1; end
            end
            M_STOP: begin
                if (ev == 3) m_st = M_RUN;
                else if (ev == 1) begin m_st = M_IDLE; clr = 1'b1; end
                else if (ev == 2) m_st = C_IDLE;
            end
            C_IDLE: begin
                if (ev == 1) load = 1'b1;
                else if (ev == 3 && !cz) m_st = C_RUN;
                else if (ev == 2) m_st = M_IDLE;
            end
            C_RUN: begin
                if (cz) begin m_st = C_DONE; m_t = 0; end
                else if (ev == 3) m_st = C_PAUSE;
            end
            C_PAUSE: begin
                if (ev == 3) m_st = C_RUN;
                else if (ev == 1) begin m_st = C_IDLE; load = 1'b1; end
            end
            C_DONE: begin
                if (ev == 3 || ev == 1) begin m_st = C_IDLE; load = 1'b1; end
                else if (ev == 2) m_st = M_IDLE;
                else begin
                    m_t++;
                    if (m_t == ALARMN * BLINK) begin m_st = C_IDLE; load = 1'b1; end
                end
            end
            default: m_st = M_IDLE;
        endcase
        if (prev == M_RUN && m_st == M_LAP && m_lcnt < 15) m_lcnt++;
        if (clr) m_lcnt = 0;
        e[6] = (m_st == M_RUN) || (m_st == M_LAP);
        e[5] = clr;
        e[4] = (m_st == M_LAP) || (m_st == M_LSTOP);
        e[3] = (m_st >= C_IDLE);
        e[2] = (m_st == C_RUN);
        e[1] = load;
        e[0] = (m_st == C_DONE) && (((m_t / BLINK) % 2) == 0);
`ifdef LAP_CNT_EN
        e[10:7] = 4'(m_lcnt);
`else
        e[10:7] = 4'd0;
`endif
        btn = b;
        cd_zero = cz;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drive(input logic [3:0] b, input logic cz, input int n, input string tag);
        repeat (n) begin
            @(negedge mclk);
            apply(b, cz, tag);
        end
    endtask

    task automatic press(input logic [3:0] b, input logic cz, input string tag);
        drive(b, cz, 6, tag);
        drive(4'd0, cz, 8, tag);
    endtask

    initial begin : monitor
        logic [10:0] e;
        string       t;
        forever begin
            @(posedge mclk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, dut_v, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] rb;
        logic       rcz;
        int         r;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        check("reset_state", dut_v, 11'd0);
        @(negedge mclk);
        rst_n = 1'b1;
        apply(4'd0, 1'b0, "idle");
        drive(4'd0, 1'b0, 4, "idle");

        drive(4'b0001, 1'b0, 3, "glitch");
        drive(4'd0, 1'b0, 10, "glitch");
        press(4'b0001, 1'b0, "start_run");
        press(4'b0010, 1'b0, "lap");
        press(4'b0001, 1'b0, "lstop");
        press(4'b0010, 1'b0, "stop");
        press(4'b0100, 1'b0, "reset_clr");

        press(4'b0001, 1'b0, "run2");
        press(4'b0100, 1'b0, "rst_ign_run");
        press(4'b1000, 1'b0, "mode_ign_run");
        press(4'b0001, 1'b0, "stop2");
        press(4'b0101, 1'b0, "rst_start_stop");

        press(4'b1000, 1'b0, "to_cd");
        press(4'b0001, 1'b1, "cd_start_zero");
        press(4'b0001, 1'b0, "cd_run");
        drive(4'b0001, 1'b0, 6, "cd_zero_start");
        drive(4'd0, 1'b1, 8, "cd_done");
        drive(4'd0, 1'b0, 20, "alarm_seq");

        press(4'b0100, 1'b0, "cd_reload");
        press(4'b0001, 1'b0, "cd_run2");
        press(4'b0001, 1'b0, "cd_pause");
        press(4'b0100, 1'b0, "cd_pause_rst");
        press(4'b0001, 1'b0, "cd_run3");
        drive(4'd0, 1'b1, 4, "cd_done2");
        drive(4'd0, 1'b0, 2, "cd_done2");
        press(4'b1000, 1'b0, "done_mode");

        press(4'b0001, 1'b0, "lc_run");
        for (int i = 0; i < 17; i++) begin
            press(4'b0010, 1'b0, "lc_lap");
            press(4'b0010, 1'b0, "lc_unlap");
        end
        press(4'b0001, 1'b0, "lc_stop");
        press(4'b0100, 1'b0, "lc_clr");

        press(4'b0001, 1'b0, "ar_run");
        press(4'b0010, 1'b0, "ar_lap");
        @(posedge mclk);
        #3;
        rst_n = 1'b0;
        btn = 4'd0;
        cd_zero = 1'b0;
        #1;
        check("async_rst", dut_v, 11'd0);
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        check("rst_hold", dut_v, 11'd0);
        @(negedge mclk);
        rst_n = 1'b1;
        apply(4'd0, 1'b0, "post_rst");

        rcz = 1'b0;
        for (int s = 0; s < 200; s++) begin
            r = $urandom_range(0, 7);
            if (r < 4) rb = 4'(1 << r);
            else if (r == 4) rb = 4'($urandom_range(0, 15));
            else rb = 4'd0;
            if ($urandom_range(0, 3) == 0) rcz = ~rcz;
            drive(rb, rcz, $urandom_range(1, 12), "random");
        end
        drive(4'd0, 1'b0, 20, "drain");

        repeat (2) @(posedge mclk);
        #2;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sw_ctrl_fsm.md
Name: sw_ctrl_fsm

Overview:
Front-panel controller for the stopwatch/countdown datapath. It synchronizes and debounces the four push-buttons, turns them into one-cycle press events, and runs the mode/run/lap state machine. It drives the count enables, clear, lap-freeze, countdown-load and alarm controls consumed by the counter chain, lap register, display muxes and countdown counter. It replaces ad-hoc switch decoding with a single sequenced control point.

Parameters:
DEB_CYCLES, 250000, consecutive mclk cycles a synchronized button must hold a new level before the debounced level changes
BLINK_CYCLES, 12500000, mclk cycles per alarm output half-period
ALARM_CYCLES, 8, alarm half-periods in CD_DONE before automatic return to CD_IDLE

Ports:
mclk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
btn  in  4  raw buttons, active high: [0] start/stop, [1] lap, [2] reset, [3] mode
cd_zero  in  1  countdown value equals zero, synchronous to mclk
sw_run  out  1  stopwatch count enable
sw_clr  out  1  one-cycle stopwatch counter clear
lap  out  1  lap freeze; 1 = display holds captured value
mode  out  1  0 = stopwatch, 1 = countdown; also drives mode LED
cd_run  out  1  countdown count enable
cd_load  out  1  one-cycle pulse: load countdown preset from DSW
alarm  out  1  blinking alarm indicator

Behaviour:
- Reset (rst_n=0, async): state SW_IDLE, all outputs 0, debounced levels 0, all counters 0.
- Input path: 2-flop synchronizer per button; a per-button counter is cleared when the synced level equals the debounced level, else increments; the debounced level flips when the counter reaches DEB_CYCLES-1.
- Press event = debounced rising edge, 1 cycle wide. Press to FSM reaction = 1 cycle. Release is ignored.
- Same-cycle priority: reset > mode > start > lap. Only the highest-priority press is acted on; the rest are dropped.
- Stopwatch states (mode=0). Each state lists (sw_run, lap):
  - SW_IDLE (0,0): start -> SW_RUN; mode -> CD_IDLE.
  - SW_RUN (1,0): start -> SW_STOP; lap -> SW_LAP.
  - SW_LAP (1,1): lap -> SW_RUN; start -> SW_LSTOP.
  - SW_LSTOP (0,1): lap -> SW_STOP; start -> SW_LAP; reset -> SW_IDLE.
  - SW_STOP (0,0): start -> SW_RUN; reset -> SW_IDLE; mode -> CD_IDLE.
- Reset press is ignored in SW_RUN and SW_LAP. Mode press is ignored in every state except SW_IDLE, SW_STOP, CD_IDLE and CD_DONE.
- sw_clr pulses for exactly 1 cycle on each transition into SW_IDLE from SW_STOP or SW_LSTOP.
- Countdown states (mode=1), outputs cd_run=1 only in CD_RUN:
  - CD_IDLE: reset -> cd_load pulse, stays in CD_IDLE; start -> CD_RUN only when cd_zero=0, otherwise ignored; mode -> SW_IDLE.
  - CD_RUN: cd_zero=1 -> CD_DONE. cd_zero beats a start press in the same cycle. start -> CD_PAUSE.
  - CD_PAUSE: start -> CD_RUN; reset -> CD_IDLE with cd_load.
  - CD_DONE: alarm toggles every BLINK_CYCLES, starting at 1. A start or reset press, or the ALARM_CYCLES-th half-period expiring, goes to CD_IDLE with a cd_load pulse and alarm=0. A mode press goes to SW_IDLE with alarm=0 and no cd_load.
- mode output is registered and equals 1 in all CD_* states. The stopwatch counter value is kept across mode changes; the stopwatch always re-enters in SW_IDLE and is cleared only by sw_clr.
- All outputs are registered; no combinational path from btn or cd_zero to any output.
- Counter widths: $clog2 of the respective parameter, at least 1 bit. Timers saturate and never wrap.

Optional Feature:
LAP_CNT_EN: adds output lap_cnt[3:0]. It increments on every transition SW_RUN->SW_LAP and saturates at 15. It is cleared by reset and by sw_clr. Without the macro the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DEB_CYCLES=4: 3-cycle glitch on btn[0] -> no state change; hold 6 cycles -> sw_run=1 exactly 4+2+1 cycles after the edge.
- Stopwatch sequence start, lap, start, lap, reset -> states RUN, LAP, LSTOP, STOP, IDLE; sw_clr high 1 cycle; (sw_run, lap) = (1,0), (1,1), (0,1), (0,0), (0,0).
- Reset press in SW_RUN -> ignored, sw_run stays 1, no sw_clr. Mode press in SW_RUN -> ignored, mode stays 0.
- Countdown: mode, then start with cd_zero=0 -> cd_run=1. Force cd_zero=1 in the same cycle as a start press -> CD_DONE, alarm=1. BLINK_CYCLES=2, ALARM_CYCLES=8 -> alarm toggles 8 times, then cd_load pulses once and mode stays 1.
- Simultaneous reset+start press in SW_STOP -> SW_IDLE with sw_clr, no run. Start in CD_IDLE with cd_zero=1 -> stays idle.
- rst_n asserted mid-SW_LAP (async, between edges) -> all outputs 0 immediately. LAP_CNT_EN build: 17 lap captures -> lap_cnt=15, then reset press in SW_STOP -> lap_cnt=0.
